byte_serializer: RTL
====================

Name: byte_serializer

Overview:
Parallel-to-serial readback block. On request, it captures an 8-bit value, typically the output of a latched configuration/data register, and shifts it off-chip over a 3-wire SPI-mode-0-style link (cs_n, sclk, sdo). It is the read side of the team's latched-register path and lets an external host read back latched bytes through a few spare output pins.

Parameters:
CLK_DIV, 2, half-period of sclk in clk cycles; legal range ≥1; sclk frequency = clk/(2*CLK_DIV)
MSB_FIRST, 1, 1 = shift bit 7 first; 0 = shift bit 0 first

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  transfer request; sampled only in IDLE
din  input  8  byte to send; captured in the cycle start is accepted
busy  output  1  high while a transfer is in progress
done  output  1  one-cycle pulse when a transfer completes
cs_n  output  1  chip select, active low
sclk  output  1  serial clock, idle low
sdo  output  1  serial data; changes only while sclk is low

Behaviour:
- Reset, synchronous: after a rising edge with rst=1, outputs are busy=0, done=0, cs_n=1, sclk=0, sdo=0; state=IDLE; counters=0; shift register=0. rst has priority over every other event.
- States: IDLE -> SHIFT -> HOLD -> DONE -> IDLE.
- IDLE: cs_n=1, sclk=0, sdo=0, busy=0.
  - If start=1 in cycle T: capture din into the shift register and enter SHIFT.
  - In cycle T+1: busy=1, cs_n=0, sclk=0, sdo=first bit.
- SHIFT: 8 bit windows, each 2*CLK_DIV cycles long.
  - Low half: CLK_DIV cycles, sclk=0.
  - High half: CLK_DIV cycles, sclk=1.
  - sdo advances to the next bit on the cycle sclk returns low.
  - Bit k (k=0..7, transmit order) rises at T+1+(2k+1)*CLK_DIV; the receiver samples on that rising edge.
- HOLD: entered at T+1+16*CLK_DIV. sclk=0, cs_n=0, sdo holds the last bit, for CLK_DIV cycles.
- DONE: one cycle at T+1+17*CLK_DIV. cs_n=1, sclk=0, sdo=0, busy=0, done=1. Next cycle returns to IDLE.
- Counters:
  - Clock-divider counter width $clog2(CLK_DIV)+1; it wraps to 0 at CLK_DIV-1.
  - Bit counter 3 bits; it wraps after bit 7 into HOLD.
- start is ignored in SHIFT, HOLD and DONE; no queuing.
- Changes on din after capture have no effect on the current transfer.
- start held continuously: the next transfer is accepted in the IDLE cycle after DONE, so busy is low for exactly 2 cycles between transfers.
- Reset mid-transfer: all outputs return to reset values on the next edge. No done pulse, no partial resume.
- CLK_DIV=1: sclk toggles every cycle (clk/2). Total busy duration is 17*CLK_DIV cycles.
- sclk and cs_n are driven directly from registers; no combinational path from any input to any output.

Test Plan:
- CLK_DIV=2, MSB_FIRST=1, rst released, start=1 with din=0xA5 at cycle T -> cs_n falls at T+1; sdo sampled at the 8 sclk rising edges (T+3, T+7, …, T+31) = 1,0,1,0,0,1,0,1; done=1 only at T+35; cs_n=1 at T+35.
- MSB_FIRST=0, din=0x01 -> sampled bits 1,0,0,0,0,0,0,0; with MSB_FIRST=1 -> 0,0,0,0,0,0,0,1.
- Transfer of 0x3C in progress; at cycle T+10 pulse start=1 with din=0xFF -> ignored; bits still 0,0,1,1,1,1,0,0; exactly one done pulse.
- rst=1 asserted at T+12 mid-transfer -> at T+13: cs_n=1, sclk=0, sdo=0, busy=0; done stays 0 indefinitely; a new start afterwards sends a complete byte correctly.
- start held high, din=0x81 then 0x7E -> two back-to-back transfers; busy low for exactly 2 cycles between them; bytes 0x81 and 0x7E are received intact.
- CLK_DIV=1, din=0xF0 -> sclk period 2 cycles; busy high for 17 cycles; sampled bits 1,1,1,1,0,0,0,0.

Source files
------------

// File: rtl/byte_serializer.sv
// rtl/byte_serializer.sv - parallel-to-serial byte readback over a cs_n/sclk/sdo link
module byte_serializer #(
    parameter int CLK_DIV   = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic       cs_n,
    output logic       sclk,
    output logic       sdo
);

    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [DW-1:0] div_cnt, div_cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          busy_n, done_n, cs_n_n, sclk_n, sdo_n;

    // State, counters and every output are registered so no input reaches a pin combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cs_n    <= 1'b1;
            sclk    <= 1'b0;
            sdo     <= 1'b0;
        end else begin
            state   <= state_n;
            div_cnt <= div_cnt_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            busy    <= busy_n;
            done    <= done_n;
            cs_n    <= cs_n_n;
            sclk    <= sclk_n;
            sdo     <= sdo_n;
        end
    end

    // Next-state logic; output values are computed one cycle ahead so they land with the new state
    always_comb begin
        state_n   = state;
        div_cnt_n = div_cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        busy_n    = busy;
        done_n    = 1'b0;
        cs_n_n    = cs_n;
        sclk_n    = sclk;
        sdo_n     = sdo;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = SHIFT;
                    shreg_n   = din;
                    div_cnt_n = '0;
                    bit_cnt_n = '0;
                    busy_n    = 1'b1;
                    cs_n_n    = 1'b0;
                    sclk_n    = 1'b0;
                    sdo_n     = (MSB_FIRST != 0) ? din[7] : din[0];
                end
            end

            SHIFT: begin
                if (div_cnt == DIV_MAX) begin
                    div_cnt_n = '0;
                    if (!sclk) begin
                        sclk_n = 1'b1;
                    end else begin
                        sclk_n = 1'b0;
                        if (bit_cnt == 3'd7) begin
                            // Last bit stays on sdo through HOLD
                            bit_cnt_n = '0;
                            state_n   = HOLD;
                        end else begin
                            bit_cnt_n = bit_cnt + 3'd1;
                            if (MSB_FIRST != 0) begin
                                shreg_n = {shreg[6:0], 1'b0};
                                sdo_n   = shreg[6];
                            end else begin
                                shreg_n = {1'b0, shreg[7:1]};
                                sdo_n   = shreg[1];
                            end
                        end
                    end
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end

            HOLD: begin
                if (div_cnt == DIV_MAX) begin
                    div_cnt_n = '0;
                    state_n   = DONE;
                    busy_n    = 1'b0;
                    done_n    = 1'b1;
                    cs_n_n    = 1'b1;
                    sdo_n     = 1'b0;
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
